aes_kat_runner: RTL and testbench

AES_KAT_RUNNER -- requirements
Module: aes_kat_runner

---
 rtl/aes_kat_runner.sv | 200 ++++++++++++++++++++
 tb/tb_aes_kat_runner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_runner.sv
// aes_kat_runner: AES known-answer-test sequencer.
// Stores DEPTH key/plaintext/ciphertext vectors, feeds each one to an external
// cipher core, compares the core result against the stored ciphertext and
// reports pass/fail counts plus the index of the first failing vector.
// Optional feature: define AES_KAT_TIMEOUT_EN to bound each core wait to
// TIMEOUT cycles (a timed-out vector counts as a fail and sets timeout_err).
module aes_kat_runner #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [127:0]   wr_key,
    input  logic [127:0]   wr_pt,
    input  logic [127:0]   wr_ct,
    input  logic [AW:0]    num_vec,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [AW:0]    pass_cnt,
    output logic [AW:0]    fail_cnt,
    output logic [AW:0]    first_fail,
    output logic           core_ld,
    output logic [127:0]   core_key,
    output logic [127:0]   core_text_in,
    input  logic           core_done,
    input  logic [127:0]   core_text_out,
    output logic           timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    localparam logic [AW:0] NV_MAX = (AW+1)'(DEPTH);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 1 || DEPTH > 256 || (1 << AW) < DEPTH) begin : g_bad_depth
        $error("aes_kat_runner: DEPTH/AW out of range");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("aes_kat_runner: TIMEOUT out of range");
    end

    state_t        r_state;
    logic [127:0]  r_key_mem [DEPTH];
    logic [127:0]  r_pt_mem  [DEPTH];
    logic [127:0]  r_ct_mem  [DEPTH];
    logic [AW:0]   r_nv;
    logic [AW:0]   r_idx;
    logic [127:0]  r_result;

    logic          w_wr;
    logic          w_bypass0;
    logic [AW:0]   w_nv;
    logic [AW:0]   w_idx_nxt;
    logic [127:0]  w_key0;
    logic [127:0]  w_pt0;
    logic [127:0]  w_keyn;
    logic [127:0]  w_ptn;
    logic          w_match;
    logic          w_pass;

    assign w_wr      = wr_en && (r_state == S_IDLE);
    assign w_nv      = (num_vec > NV_MAX) ? NV_MAX : num_vec;
    assign w_idx_nxt = r_idx + (AW+1)'(1);
    // Entry 0 is fetched on the same edge a simultaneous write lands, so
    // forward the write data to make it visible to the run.
    assign w_bypass0 = w_wr && (wr_addr == '0);
    assign w_key0    = w_bypass0 ? wr_key : r_key_mem[0];
    assign w_pt0     = w_bypass0 ? wr_pt  : r_pt_mem[0];
    assign w_keyn    = r_key_mem[w_idx_nxt[AW-1:0]];
    assign w_ptn     = r_pt_mem[w_idx_nxt[AW-1:0]];
    assign w_match   = (r_result == r_ct_mem[r_idx[AW-1:0]]);

`ifdef AES_KAT_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_wcnt;
    logic        r_tmo;
    logic        r_tmo_err;
    assign w_pass      = w_match && !r_tmo;
    assign timeout_err = r_tmo_err;
`else
    assign w_pass      = w_match;
    assign timeout_err = 1'b0;
`endif

    // Vector buffer: not reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_key_mem[wr_addr] <= wr_key;
            r_pt_mem[wr_addr]  <= wr_pt;
            r_ct_mem[wr_addr]  <= wr_ct;
        end
    end

    // Run sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            core_ld      <= 1'b0;
            core_key     <= '0;
            core_text_in <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            first_fail   <= '1;
            r_nv         <= '0;
            r_idx        <= '0;
            r_result     <= '0;
`ifdef AES_KAT_TIMEOUT_EN
            r_wcnt       <= '0;
            r_tmo        <= 1'b0;
            r_tmo_err    <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            core_ld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        first_fail <= '1;
                        r_nv       <= w_nv;
                        r_idx      <= '0;
`ifdef AES_KAT_TIMEOUT_EN
                        r_tmo_err  <= 1'b0;
`endif
                        if (w_nv == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            core_ld      <= 1'b1;
                            core_key     <= w_key0;
                            core_text_in <= w_pt0;
                            r_state      <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
`ifdef AES_KAT_TIMEOUT_EN
                    r_wcnt <= '0;
                    r_tmo  <= 1'b0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_result <= core_text_out;
                        r_state  <= S_CHECK;
                    end
`ifdef AES_KAT_TIMEOUT_EN
                    else if (r_wcnt == TMO_LAST) begin
                        r_tmo     <= 1'b1;
                        r_tmo_err <= 1'b1;
                        r_state   <= S_CHECK;
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                    end
`endif
                end
                S_CHECK: begin
                    if (w_pass) begin
                        pass_cnt <= pass_cnt + (AW+1)'(1);
                    end else begin
                        fail_cnt <= fail_cnt + (AW+1)'(1);
                        if (first_fail == '1) begin
                            first_fail <= r_idx;
                        end
                    end
                    r_idx <= w_idx_nxt;
                    if (w_idx_nxt == r_nv) begin
                        r_state <= S_FINISH;
                    end else begin
                        core_ld      <= 1'b1;
                        core_key     <= w_keyn;
                        core_text_in <= w_ptn;
                        r_state      <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_kat_runner.sv
// tb_aes_kat_runner: directed bench for aes_kat_runner with a behavioural
// cipher-core model (result = key ^ pt, 10 cycles after core_ld) and a
// run-result scoreboard. Define AES_KAT_TIMEOUT_EN to exercise the timeout.
module tb_aes_kat_runner;

    typedef struct packed {
        logic [3:0] p;
        logic [3:0] f;
        logic [3:0] ff;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [127:0] wr_key, wr_pt, wr_ct;
    logic [3:0]   num_vec;
    logic         start;
    logic         busy, done, core_ld, timeout_err;
    logic [3:0]   pass_cnt, fail_cnt, first_fail;
    logic [127:0] core_key, core_text_in;
    logic         core_done = 1'b0;
    logic [127:0] core_text_out = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0, start_cyc = 0, ld_cyc = 0, done_cyc = 0;
    int ld_count = 0, done_count = 0;
    int mdl_cnt = 0;
    bit never_done = 1'b0;
    logic [127:0] mdl_res;
    logic [127:0] tkey [8], tpt [8], tct [8];
    res_t exp_q [$];

    aes_kat_runner #(.DEPTH(8), .AW(3), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_key(wr_key), .wr_pt(wr_pt), .wr_ct(wr_ct), .num_vec(num_vec),
        .start(start), .busy(busy), .done(done), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .first_fail(first_fail), .core_ld(core_ld),
        .core_key(core_key), .core_text_in(core_text_in), .core_done(core_done),
        .core_text_out(core_text_out), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: core_done is high in the 10th cycle after the core_ld cycle.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_ld) begin
            mdl_cnt <= 9;
            mdl_res <= core_key ^ core_text_in;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1 && !never_done) begin
                core_done     <= 1'b1;
                core_text_out <= mdl_res;
            end
        end
    end

    // Event monitor and scoreboard pop on done.
    always @(posedge clk) begin
        res_t e;
        cyc++;
        if (start && !busy && !rst) start_cyc = cyc;
        if (core_ld) begin
            ld_count++;
            if (ld_count == 1) ld_cyc = cyc;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_empty: observed done with no pending run expected none");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pass_cnt", 128'(pass_cnt), 128'(e.p));
                check("fail_cnt", 128'(fail_cnt), 128'(e.f));
                check("first_fail", 128'(first_fail), 128'(e.ff));
            end
        end
    end

    function automatic res_t model(input logic [3:0] nv, input bit all_fail);
        res_t r;
        int n;
        r.p = 0; r.f = 0; r.ff = 4'hF;
        n = (nv > 8) ? 8 : int'(nv);
        for (int i = 0; i < n; i++) begin
            if (!all_fail && tct[i] === (tkey[i] ^ tpt[i])) r.p++;
            else begin
                r.f++;
                if (r.ff == 4'hF) r.ff = 4'(i);
            end
        end
        return r;
    endfunction

    task automatic do_write(input logic [2:0] a, input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_key = k; wr_pt = p; wr_ct = c;
        tkey[a] = k; tpt[a] = p; tct[a] = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] nv, input bit all_fail);
        exp_q.push_back(model(nv, all_fail));
        ld_count = 0;
        @(negedge clk);
        start = 1'b1; num_vec = nv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        base = done_count;
        for (int i = 0; i < budget && done_count == base; i++) @(negedge clk);
        checks++;
        assert (done_count != base) else begin
            errors++;
            $error("FAIL %s: observed no done expected done within %0d cycles", tag, budget);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_core_ld"}, 128'(core_ld), 128'(0));
        check({tag, "_core_key"}, core_key, '0);
        check({tag, "_core_text"}, core_text_in, '0);
        check({tag, "_pass"}, 128'(pass_cnt), 128'(0));
        check({tag, "_fail"}, 128'(fail_cnt), 128'(0));
        check({tag, "_ffail"}, 128'(first_fail), 128'(4'hF));
        check({tag, "_tmo"}, 128'(timeout_err), 128'(0));
    endtask

    initial begin
        int dc;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_key = '0; wr_pt = '0; wr_ct = '0;
        num_vec = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Single known vector: latency check.
        do_write(3'd0, 128'hcafebabedeadbeefdeadbeef00000000, 128'h468D529628E0B29C45F3D36EAEEE6751,
                 128'hcafebabedeadbeefdeadbeef00000000 ^ 128'h468D529628E0B29C45F3D36EAEEE6751);
        start_run(4'd1, 1'b0);
        check("busy_running", 128'(busy), 128'(1));
        wait_done("done_1vec", 40);
        check("ld_latency", 128'(ld_cyc - start_cyc), 128'(1));
        check("done_latency", 128'(done_cyc - start_cyc), 128'(14));
        check("ld_count_1", 128'(ld_count), 128'(1));
        check("done_single_pulse", 128'(done), 128'(0));
        check("busy_after_done", 128'(busy), 128'(0));

        // Eight vectors, 2 and 5 corrupt; entry 0 written in the start cycle.
        for (int i = 1; i < 8; i++) begin
            logic [127:0] k, p;
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            do_write(3'(i), k, p, (i == 2 || i == 5) ? (k ^ p ^ 128'h1) : (k ^ p));
        end
        @(negedge clk);
        tkey[0] = 128'h0123456789abcdef0011223344556677;
        tpt[0]  = 128'hfedcba98765432108899aabbccddeeff;
        tct[0]  = tkey[0] ^ tpt[0];
        wr_en = 1'b1; wr_addr = 3'd0; wr_key = tkey[0]; wr_pt = tpt[0]; wr_ct = tct[0];
        exp_q.push_back(model(4'd8, 1'b0));
        ld_count = 0;
        start = 1'b1; num_vec = 4'd8;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        // Ignored while busy: a bogus write to entry 3 and a second start.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_ct = '1; start = 1'b1; num_vec = 4'd1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_done("done_8vec", 200);
        check("ld_count_8", 128'(ld_count), 128'(8));

        // Zero-length run.
        start_run(4'd0, 1'b0);
        wait_done("done_0vec", 10);
        check("done_latency_0", 128'(done_cyc - start_cyc), 128'(2));
        check("ld_count_0", 128'(ld_count), 128'(0));

        // num_vec above DEPTH clamps to DEPTH.
        start_run(4'd15, 1'b0);
        wait_done("done_clamp", 200);
        check("ld_count_clamp", 128'(ld_count), 128'(8));

        // Reset in WAIT of vector 3 abandons the run.
        start_run(4'd8, 1'b0);
        for (int i = 0; i < 100 && ld_count < 4; i++) @(negedge clk);
        check("reached_vec3", 128'(ld_count), 128'(4));
        repeat (3) @(negedge clk);
        dc = done_count;
        rst = 1'b1;
        #1;
        check_reset_vals("midrun");
        repeat (15) @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("no_done_on_abort", 128'(done_count), 128'(dc));
        start_run(4'd8, 1'b0);
        wait_done("done_rerun", 200);
        check("ld_count_rerun", 128'(ld_count), 128'(8));

        // Core that never responds.
        never_done = 1'b1;
`ifdef AES_KAT_TIMEOUT_EN
        start_run(4'd2, 1'b1);
        wait_done("done_timeout", 100);
        check("timeout_latency", 128'(done_cyc - start_cyc), 128'(38));
        check("timeout_err_set", 128'(timeout_err), 128'(1));
        never_done = 1'b0;
        repeat (12) @(negedge clk);
        start_run(4'd8, 1'b0);
        wait_done("done_after_tmo", 200);
        check("timeout_err_clr", 128'(timeout_err), 128'(0));
`else
        dc = done_count;
        start_run(4'd2, 1'b0);
        repeat (200) @(negedge clk);
        check("busy_hangs", 128'(busy), 128'(1));
        check("no_done_hang", 128'(done_count), 128'(dc));
        check("timeout_err_zero", 128'(timeout_err), 128'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        never_done = 1'b0;
`endif
        check("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
